// File: rtl/encounter_gen.sv
// Random wild-encounter generator for the overworld: detects tile-aligned player
// steps once per frame, rolls an LFSR on grass, and hands off to battle mode.
module encounter_gen #(
  parameter logic [7:0]  ENC_THRESH = 8'd26,
  parameter int unsigned COOLDOWN   = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        vclk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [10:0] map_x_in,
  input  logic [9:0]  map_y_in,
  input  logic        grass_in,
  input  logic        start_battle_in,
  input  logic        start_over_in,
  output logic        battle_trigger_out,
  output logic [2:0]  species_out,
  output logic [3:0]  level_out,
  output logic [7:0]  enc_count_out
);

  typedef enum logic [2:0] {
    ROAM      = 3'd0,
    CHECK     = 3'd1,
    TRIGGER   = 3'd2,
    IN_BATTLE = 3'd3,
    COOL      = 3'd4
  } state_t;

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_lfsr;
  logic        r_pix0_d;
  logic        r_frame_tick;
  logic [10:0] r_last_x;
  logic [9:0]  r_last_y;
  logic [7:0]  r_cool;
  logic [7:0]  w_cool_next;
  logic        r_trigger;
  logic        w_trigger_next;
  logic [2:0]  r_species;
  logic [2:0]  w_species_next;
  logic [3:0]  r_level;
  logic [3:0]  w_level_next;
  logic [7:0]  r_count;
  logic [7:0]  w_count_next;

  logic        w_pix0;
  logic        w_lfsr_fb;
  logic        w_aligned;
  logic        w_moved;
  logic        w_step;

  assign w_pix0    = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_aligned = (map_x_in[3:0] == 4'd0) && (map_y_in[3:0] == 4'd0);
  assign w_moved   = ({map_x_in, map_y_in} != {r_last_x, r_last_y});
  assign w_step    = r_frame_tick && w_aligned && w_moved;

  // Right-shifting Fibonacci form of taps 16,14,13,11; free-running so the
  // roll depends on when the player lands on the tile.
  always_ff @(posedge vclk_in or posedge rst_in) begin
    if (rst_in) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // Tick is the registered rising edge of the pixel-origin match, so a stalled
  // raster parked at (0,0) still yields a single tick.
  always_ff @(posedge vclk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pix0_d     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_pix0_d     <= w_pix0;
      r_frame_tick <= w_pix0 && !r_pix0_d;
    end
  end

  always_ff @(posedge vclk_in or posedge rst_in) begin
    if (rst_in) begin
      r_last_x <= 11'd0;
      r_last_y <= 10'd0;
    end else if (w_step) begin
      r_last_x <= map_x_in;
      r_last_y <= map_y_in;
    end
  end

  always_ff @(posedge vclk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ROAM;
      r_cool    <= 8'd0;
      r_trigger <= 1'b0;
      r_species <= 3'd0;
      r_level   <= 4'd0;
      r_count   <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_cool    <= w_cool_next;
      r_trigger <= w_trigger_next;
      r_species <= w_species_next;
      r_level   <= w_level_next;
      r_count   <= w_count_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cool_next    = r_cool;
    w_trigger_next = r_trigger;
    w_species_next = r_species;
    w_level_next   = r_level;
    w_count_next   = r_count;
    case (r_state)
      ROAM: begin
        if (w_step && grass_in) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (r_lfsr[7:0] < ENC_THRESH) begin
          w_trigger_next = 1'b1;
          w_species_next = r_lfsr[10:8];
          w_level_next   = 4'd2 + {1'b0, r_lfsr[13:11]};
          w_count_next   = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
          w_state_next   = TRIGGER;
        end else begin
          w_state_next = ROAM;
        end
      end
      TRIGGER: begin
        if (start_battle_in) begin
          w_trigger_next = 1'b0;
          w_state_next   = IN_BATTLE;
        end
      end
      IN_BATTLE: begin
        // Both mode levels high means the battle screen has not released yet.
        if (start_over_in && !start_battle_in) begin
          if (COOL_LOAD == 8'd0) begin
            w_cool_next  = 8'd0;
            w_state_next = ROAM;
          end else begin
            w_cool_next  = COOL_LOAD;
            w_state_next = COOL;
          end
        end
      end
      COOL: begin
        if (w_step) begin
          if (r_cool <= 8'd1) begin
            w_cool_next  = 8'd0;
            w_state_next = ROAM;
          end else begin
            w_cool_next = r_cool - 8'd1;
          end
        end
      end
      default: begin
        w_state_next = ROAM;
      end
    endcase
  end

  assign battle_trigger_out = r_trigger;
  assign species_out        = r_species;
  assign level_out          = r_level;
  assign enc_count_out      = r_count;

endmodule

// File: tb/tb_encounter_gen.sv
// Self-checking bench for encounter_gen: predicts the free-running LFSR to time
// steps onto hits or misses, and scoreboards each step's outcome.
`timescale 1ns/1ps
module tb_encounter_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] hcount = 11'd1;
  logic [9:0]  vcount = 10'd0;
  logic [10:0] map_x = 11'd0;
  logic [9:0]  map_y = 10'd0;
  logic        grass = 1'b0;
  logic        start_battle = 1'b0;
  logic        start_over = 1'b0;
  logic        trig;
  logic [2:0]  species;
  logic [3:0]  level;
  logic [7:0]  enc_count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       trig;
    logic [2:0] sp;
    logic [3:0] lv;
    logic [7:0] cnt;
    string      name;
  } exp_t;
  exp_t sb[$];

  logic [2:0]  e_sp  = 3'd0;
  logic [3:0]  e_lv  = 4'd0;
  logic [7:0]  e_cnt = 8'd0;
  int          pidx  = 1;
  logic [15:0] m;

  encounter_gen dut (
    .vclk_in            (clk),
    .rst_in             (rst),
    .hcount_in          (hcount),
    .vcount_in          (vcount),
    .map_x_in           (map_x),
    .map_y_in           (map_y),
    .grass_in           (grass),
    .start_battle_in    (start_battle),
    .start_over_in      (start_over),
    .battle_trigger_out (trig),
    .species_out        (species),
    .level_out          (level),
    .enc_count_out      (enc_count)
  );

  always #8 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Reference LFSR: seed 16'hACE1, one advance per clock outside reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m <= 16'hACE1;
    else     m <= adv(m);
  end

  function automatic logic roll_ok(input logic [15:0] l, input int mode);
    if (mode == 0) return l[7:0] >= 8'd26;
    if (mode == 1) return l[7:0] < 8'd26;
    return 1'b1;
  endfunction

  task automatic next_pos(output logic [10:0] x, output logic [9:0] y);
    x = 11'(((pidx % 120) + 1) * 16);
    y = 10'((((pidx / 120) % 60) + 1) * 16);
    pidx++;
  endtask

  // One frame tick at (x,y). mode: 0 = time CHECK onto a miss, 1 = onto a hit,
  // 2 = no timing. CHECK sees the LFSR two advances after the driving negedge.
  task automatic do_step(input string name, input logic [10:0] x, input logic [9:0] y,
                         input logic g, input int mode, input logic exp_trig);
    logic [15:0] l2;
    exp_t e;
    exp_t got;
    int waited;
    waited = 0;
    l2 = adv(adv(m));
    while (!roll_ok(l2, mode) && waited < 300) begin
      @(negedge clk);
      waited++;
      l2 = adv(adv(m));
    end
    if (waited >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL %s lfsr_wait: waited %0d cycles, required < 300", name, waited);
    end
    if (exp_trig) begin
      e_sp = l2[10:8];
      e_lv = 4'd2 + {1'b0, l2[13:11]};
      if (e_cnt != 8'hFF) e_cnt = e_cnt + 8'd1;
    end
    e.trig = exp_trig; e.sp = e_sp; e.lv = e_lv; e.cnt = e_cnt; e.name = name;
    sb.push_back(e);
    map_x = x; map_y = y; grass = g;
    hcount = 11'd0; vcount = 10'd0;
    @(negedge clk);
    hcount = 11'd1;
    @(negedge clk);
    if (exp_trig) begin
      n_tests++;
      if (trig !== 1'b0) begin
        n_fail++;
        $display("FAIL %s latency: trigger one cycle early got %b, required 0", name, trig);
      end
    end
    @(negedge clk);
    got = sb.pop_front();
    n_tests++;
    if (trig !== got.trig) begin
      n_fail++; $display("FAIL %s trigger: got %b, required %b", got.name, trig, got.trig);
    end
    n_tests++;
    if (species !== got.sp) begin
      n_fail++; $display("FAIL %s species: got %0d, required %0d", got.name, species, got.sp);
    end
    n_tests++;
    if (level !== got.lv) begin
      n_fail++; $display("FAIL %s level: got %0d, required %0d", got.name, level, got.lv);
    end
    n_tests++;
    if (enc_count !== got.cnt) begin
      n_fail++; $display("FAIL %s count: got %0d, required %0d", got.name, enc_count, got.cnt);
    end
    $display("[TB] step %s pos=(%0d,%0d) grass=%b trig=%b sp=%0d lv=%0d cnt=%0d",
             name, x, y, g, trig, species, level, enc_count);
  endtask

  // From IN_BATTLE: release to overworld and burn the 4-step cooldown.
  task automatic leave_battle();
    logic [10:0] x;
    logic [9:0]  y;
    start_battle = 1'b0;
    start_over   = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      next_pos(x, y);
      do_step("cool", x, y, 1'b0, 2, 1'b0);
    end
    start_over = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({trig, species, level, enc_count} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0000", {trig, species, level, enc_count});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({trig, species, level, enc_count} !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset_outputs: got %h, required 0000", {trig, species, level, enc_count});
    end
  endtask

  task automatic test_miss();
    do_step("miss_16_0", 11'd16, 10'd0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_hit();
    do_step("hit_16_16", 11'd16, 10'd16, 1'b1, 1, 1'b1);
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    start_battle = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (trig !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_1000: trigger low on %0d cycles, required 0", bad);
    end
    start_battle = 1'b1;
    @(negedge clk);
    n_tests++;
    if (trig !== 1'b0) begin
      n_fail++; $display("FAIL hold_ack: got %b, required 0", trig);
    end
    $display("[TB] hold 1000 cycles then ack trig=%b", trig);
  endtask

  task automatic test_cooldown();
    logic [10:0] x;
    logic [9:0]  y;
    start_over = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_pos(x, y);
      do_step("both_high", x, y, 1'b1, 2, 1'b0);
    end
    start_battle = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      next_pos(x, y);
      do_step("cooldown_hit", x, y, 1'b1, 1, 1'b0);
    end
    start_over   = 1'b0;
    start_battle = 1'b1;
    next_pos(x, y);
    do_step("fifth_step", x, y, 1'b1, 1, 1'b1);
    @(negedge clk);
    n_tests++;
    if (trig !== 1'b0) begin
      n_fail++; $display("FAIL early_ack: got %b, required 0", trig);
    end
  endtask

  task automatic test_repeat_pos();
    logic [10:0] x;
    logic [9:0]  y;
    leave_battle();
    next_pos(x, y);
    do_step("rp_miss", x, y, 1'b1, 0, 1'b0);
    do_step("rp_same", x, y, 1'b1, 1, 1'b0);
    do_step("rp_unaligned", x + 11'd1, y, 1'b1, 1, 1'b0);
    do_step("rp_same_again", x, y, 1'b1, 1, 1'b0);
    next_pos(x, y);
    do_step("rp_new", x, y, 1'b1, 1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [10:0] x;
    logic [9:0]  y;
    start_battle = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({trig, species, level, enc_count} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h, required 0000", {trig, species, level, enc_count});
    end
    @(negedge clk);
    rst = 1'b0;
    e_sp = 3'd0; e_lv = 4'd0; e_cnt = 8'd0;
    next_pos(x, y);
    do_step("after_reset", x, y, 1'b1, 1, 1'b1);
    start_battle = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [10:0] x;
    logic [9:0]  y;
    for (int i = 2; i <= 256; i++) begin
      leave_battle();
      next_pos(x, y);
      do_step("sat", x, y, 1'b1, 1, 1'b1);
      start_battle = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (enc_count !== 8'd255) begin
      n_fail++; $display("FAIL saturate: got %0d, required 255", enc_count);
    end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_hold();
    test_cooldown();
    test_repeat_pos();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encounter_gen.md
ENCOUNTER_GEN -- requirements
Module: encounter_gen

Interface
REQ-001 SHALL have parameter ENC_THRESH, default 8'd26, meaning an encounter fires when LFSR byte < ENC_THRESH (~10%).
REQ-002 SHALL have parameter COOLDOWN, default 4, meaning grass steps ignored after a battle ends.
REQ-003 SHALL have parameter LFSR_SEED, default 16'hACE1, meaning the LFSR reset value (non-zero).
REQ-004 vclk_in  input  1  65 MHz clock, all logic on rising edge.
REQ-005 rst_in  input  1  asynchronous, active-high reset.
REQ-006 hcount_in  input  11  horizontal pixel index.
REQ-007 vcount_in  input  10  vertical pixel index.
REQ-008 map_x_in  input  11  player map x position, pixels.
REQ-009 map_y_in  input  10  player map y position, pixels.
REQ-010 grass_in  input  1  player's current tile is grass.
REQ-011 start_battle_in  input  1  battle mode active (level).
REQ-012 start_over_in  input  1  overworld mode active (level).
REQ-013 battle_trigger_out  output  1  encounter request, level, held until acknowledged.
REQ-014 species_out  output  3  encountered species index.
REQ-015 level_out  output  4  encountered level, 2..9.
REQ-016 enc_count_out  output  8  encounters issued since reset, saturating at 255.

Function
REQ-017 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every clock in every state.
REQ-018 SHALL generate frame_tick for exactly one cycle when hcount_in==0 and vcount_in==0; map inputs sampled only on frame_tick.
REQ-019 SHALL count a step on frame_tick when map_x_in[3:0]==0, map_y_in[3:0]==0, and {map_x_in,map_y_in} differs from the registered last-step position; last-step position updated on every step, grass or not.
REQ-020 SHALL implement states ROAM, CHECK, TRIGGER, IN_BATTLE, COOL.
REQ-021 ROAM: step with grass_in=1 -> CHECK; step with grass_in=0 -> stay ROAM.
REQ-022 CHECK (one cycle): lfsr[7:0] < ENC_THRESH -> latch species_out=lfsr[10:8], level_out=2+lfsr[13:11], assert battle_trigger_out, increment enc_count_out (saturating), -> TRIGGER; else -> ROAM.
REQ-023 TRIGGER: battle_trigger_out held 1; start_battle_in==1 -> deassert next cycle, -> IN_BATTLE; steps ignored.
REQ-024 IN_BATTLE: start_over_in==1 and start_battle_in==0 -> load cooldown counter with COOLDOWN, -> COOL; steps ignored.
REQ-025 COOL: each step (grass or not) decrements counter; counter reaching 0 -> ROAM; no encounters while in COOL.
REQ-026 COOLDOWN=0 SHALL make IN_BATTLE exit directly to ROAM.
REQ-027 species_out/level_out SHALL hold last latched values until the next encounter.
REQ-028 Step detection to battle_trigger_out rising SHALL be 2 cycles after the frame_tick edge (tick sample -> CHECK -> output register).
REQ-029 If start_battle_in is already 1 on TRIGGER entry, SHALL go to IN_BATTLE after one cycle of trigger assertion.
REQ-030 Simultaneous start_battle_in and start_over_in high in IN_BATTLE SHALL be treated as still in battle.

Reset
REQ-031 On rst_in asserted, asynchronously: state=ROAM, battle_trigger_out=0, species_out=0, level_out=0, enc_count_out=0, lfsr=LFSR_SEED, last-step position=0, cooldown counter=0.
REQ-032 Reset mid-TRIGGER or mid-IN_BATTLE SHALL drop battle_trigger_out immediately and resume in ROAM with no cooldown.

Verification
REQ-033 Reset release, LFSR forced so lfsr[7:0]=8'h05 at CHECK, grass step to (16,16) -> battle_trigger_out=1 two cycles after frame_tick, enc_count_out=1.
REQ-034 Same step with lfsr[7:0]=8'hF0 -> no trigger, state back to ROAM, enc_count_out unchanged.
REQ-035 Trigger held 1000 cycles with start_battle_in=0, then start_battle_in=1 -> trigger stays 1 throughout, falls next cycle.
REQ-036 After battle, start_over_in=1, four grass steps with guaranteed-hit LFSR -> no trigger; fifth grass step -> trigger.
REQ-037 Non-aligned positions (17,16) and repeated identical position (16,16) across frames -> no step counted, no CHECK.
REQ-038 rst_in pulsed mid-IN_BATTLE -> all outputs 0 same cycle, next grass hit triggers without cooldown; 256 forced encounters -> enc_count_out=255.
